// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : mc_control_fsm
//  Description : Multicycle control FSM with memory wait-state handshake,
//                bus-timeout watchdog and precise traps.
//  Revision    : 2.0 - wait states, watchdog, trap sequencing
// ============================================================================
module mc_control_fsm #(
    parameter int OPCODE_W = 6,
    parameter int WAIT_W   = 4,
    parameter int MAX_WAIT = 15,
    parameter int IRQ_EN   = 1
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                mem_ready,
    input  logic                irq,
    output logic [1:0]          ALUOp,
    output logic                ALUSrcA,
    output logic [2:0]          ALUSrcB,
    output logic [2:0]          WriteSrc,
    output logic [1:0]          WriteDest,
    output logic                CRWrite,
    output logic                RegWrite,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IorD,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic                isBranch,
    output logic                EPCWrite,
    output logic [2:0]          PCSrc,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [3:0]          current_state,
    output logic [3:0]          next_state
);

    localparam logic [3:0] c_ST_FETCH   = 4'd0;
    localparam logic [3:0] c_ST_DECODE  = 4'd1;
    localparam logic [3:0] c_ST_EXEC_C  = 4'd2;
    localparam logic [3:0] c_ST_BRANCH  = 4'd3;
    localparam logic [3:0] c_ST_JUMP    = 4'd4;
    localparam logic [3:0] c_ST_JAL     = 4'd5;
    localparam logic [3:0] c_ST_JR      = 4'd6;
    localparam logic [3:0] c_ST_LDIMM   = 4'd7;
    localparam logic [3:0] c_ST_XFER    = 4'd8;
    localparam logic [3:0] c_ST_MEMADDR = 4'd9;
    localparam logic [3:0] c_ST_MEMRD   = 4'd10;
    localparam logic [3:0] c_ST_MEMWB   = 4'd11;
    localparam logic [3:0] c_ST_MEMWR   = 4'd12;
    localparam logic [3:0] c_ST_TRAP    = 4'd13;

    localparam logic [OPCODE_W-1:0] c_OP_C    = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] c_OP_BEQ  = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] c_OP_BNE  = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] c_OP_J    = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] c_OP_JAL  = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] c_OP_JR   = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] c_OP_LUI  = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] c_OP_LLI  = OPCODE_W'(7);
    localparam logic [OPCODE_W-1:0] c_OP_MFC  = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] c_OP_MTC  = OPCODE_W'(9);
    localparam logic [OPCODE_W-1:0] c_OP_LW   = OPCODE_W'(10);
    localparam logic [OPCODE_W-1:0] c_OP_SW   = OPCODE_W'(11);
    localparam logic [OPCODE_W-1:0] c_OP_SYS  = OPCODE_W'(12);

    localparam logic [WAIT_W-1:0] c_MAX_WAIT = WAIT_W'(MAX_WAIT);

    logic [3:0]        r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [1:0]        r_trap_cause;
    logic [3:0]        w_next_state;
    logic [1:0]        w_next_cause;
    logic              w_timeout;
    logic              w_take_irq;
    logic [3:0]        w_done_state;

    // A ready arriving in the timeout cycle is a normal completion.
    assign w_timeout    = (MAX_WAIT != 0) && (r_wait_cnt == c_MAX_WAIT) && !mem_ready;
    assign w_take_irq   = (IRQ_EN != 0) && irq;
    assign w_done_state = w_take_irq ? c_ST_TRAP : c_ST_FETCH;

    always_comb begin
        w_next_state = c_ST_FETCH;
        w_next_cause = 2'b00;
        case (r_state)
            c_ST_FETCH: begin
                if (mem_ready) begin
                    w_next_state = c_ST_DECODE;
                end else if (w_timeout) begin
                    w_next_state = c_ST_TRAP;
                    w_next_cause = 2'b11;
                end else begin
                    w_next_state = c_ST_FETCH;
                end
            end
            c_ST_DECODE: begin
                case (Opcode)
                    c_OP_C:             w_next_state = c_ST_EXEC_C;
                    c_OP_BEQ, c_OP_BNE: w_next_state = c_ST_BRANCH;
                    c_OP_J:             w_next_state = c_ST_JUMP;
                    c_OP_JAL:           w_next_state = c_ST_JAL;
                    c_OP_JR:            w_next_state = c_ST_JR;
                    c_OP_LUI, c_OP_LLI: w_next_state = c_ST_LDIMM;
                    c_OP_MFC, c_OP_MTC: w_next_state = c_ST_XFER;
                    c_OP_LW, c_OP_SW:   w_next_state = c_ST_MEMADDR;
                    c_OP_SYS: begin
                        w_next_state = c_ST_TRAP;
                        w_next_cause = 2'b01;
                    end
                    default: begin
                        w_next_state = c_ST_TRAP;
                        w_next_cause = 2'b10;
                    end
                endcase
            end
            c_ST_EXEC_C, c_ST_BRANCH, c_ST_JUMP, c_ST_JAL, c_ST_JR,
            c_ST_LDIMM, c_ST_XFER, c_ST_MEMWB: begin
                w_next_state = w_done_state;
            end
            c_ST_MEMADDR: begin
                w_next_state = (Opcode == c_OP_SW) ? c_ST_MEMWR : c_ST_MEMRD;
            end
            c_ST_MEMRD: begin
                if (mem_ready) begin
                    w_next_state = c_ST_MEMWB;
                end else if (w_timeout) begin
                    w_next_state = c_ST_TRAP;
                    w_next_cause = 2'b11;
                end else begin
                    w_next_state = c_ST_MEMRD;
                end
            end
            c_ST_MEMWR: begin
                if (mem_ready) begin
                    w_next_state = w_done_state;
                end else if (w_timeout) begin
                    w_next_state = c_ST_TRAP;
                    w_next_cause = 2'b11;
                end else begin
                    w_next_state = c_ST_MEMWR;
                end
            end
            default: w_next_state = c_ST_FETCH;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state      <= c_ST_FETCH;
            r_wait_cnt   <= '0;
            r_trap_cause <= 2'b00;
        end else begin
            r_state <= w_next_state;
            if (w_next_state != r_state) begin
                r_wait_cnt <= '0;
            end else if (!mem_ready && !(&r_wait_cnt)) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end
            if (w_next_state == c_ST_TRAP) begin
                r_trap_cause <= w_next_cause;
            end
        end
    end

    // Outputs are gated by Reset so nothing reaches the datapath while it is held.
    always_comb begin
        ALUOp     = 2'b00;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 3'b000;
        WriteSrc  = 3'b000;
        WriteDest = 2'b00;
        CRWrite   = 1'b0;
        RegWrite  = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IorD      = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        isBranch  = 1'b0;
        EPCWrite  = 1'b0;
        PCSrc     = 3'b000;
        trap      = 1'b0;
        if (!Reset) begin
            case (r_state)
                c_ST_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 3'b001;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                c_ST_DECODE: ALUSrcB = 3'b011;
                c_ST_EXEC_C: begin
                    ALUSrcA  = 1'b1;
                    ALUOp    = 2'b10;
                    RegWrite = 1'b1;
                end
                c_ST_BRANCH: begin
                    ALUSrcA  = 1'b1;
                    ALUOp    = 2'b01;
                    isBranch = 1'b1;
                    PCSrc    = 3'b001;
                end
                c_ST_JUMP: begin
                    PCWrite = 1'b1;
                    PCSrc   = 3'b010;
                end
                c_ST_JAL: begin
                    PCWrite   = 1'b1;
                    PCSrc     = 3'b010;
                    RegWrite  = 1'b1;
                    WriteSrc  = 3'b001;
                    WriteDest = 2'b10;
                end
                c_ST_JR: begin
                    PCWrite = 1'b1;
                    PCSrc   = 3'b011;
                end
                c_ST_LDIMM: begin
                    RegWrite  = 1'b1;
                    WriteDest = 2'b01;
                    WriteSrc  = (Opcode == c_OP_LLI) ? 3'b011 : 3'b010;
                end
                c_ST_XFER: begin
                    if (Opcode == c_OP_MFC) begin
                        RegWrite  = 1'b1;
                        WriteSrc  = 3'b100;
                        WriteDest = 2'b01;
                    end else begin
                        CRWrite = 1'b1;
                    end
                end
                c_ST_MEMADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 3'b010;
                end
                c_ST_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                c_ST_MEMWB: begin
                    RegWrite  = 1'b1;
                    WriteSrc  = 3'b101;
                    WriteDest = 2'b01;
                end
                c_ST_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                c_ST_TRAP: begin
                    trap     = 1'b1;
                    EPCWrite = 1'b1;
                    PCWrite  = 1'b1;
                    PCSrc    = 3'b100;
                end
                default: ;
            endcase
        end
    end

    assign trap_cause    = r_trap_cause;
    assign current_state = r_state;
    assign next_state    = Reset ? c_ST_FETCH : w_next_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_control_fsm
//  Description : Instruction-level reference model and per-cycle checker.
//  Revision    : 2.0
// ============================================================================
module tb_mc_control_fsm;

    localparam int MAXW = 15;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic [5:0] Opcode = 6'd0;
    logic       mem_ready = 1'b0;
    logic       irq = 1'b0;

    logic [1:0] ALUOp, WriteDest, trap_cause;
    logic [2:0] ALUSrcB, WriteSrc, PCSrc;
    logic       ALUSrcA, CRWrite, RegWrite, MemRead, MemWrite, IorD, IRWrite;
    logic       PCWrite, isBranch, EPCWrite, trap;
    logic [3:0] current_state, next_state;

    logic [1:0] ALUOp_b, WriteDest_b, trap_cause_b;
    logic [2:0] ALUSrcB_b, WriteSrc_b, PCSrc_b;
    logic       ALUSrcA_b, CRWrite_b, RegWrite_b, MemRead_b, MemWrite_b, IorD_b, IRWrite_b;
    logic       PCWrite_b, isBranch_b, EPCWrite_b, trap_b;
    logic [3:0] current_state_b, next_state_b;

    mc_control_fsm #(.OPCODE_W(6), .WAIT_W(4), .MAX_WAIT(MAXW), .IRQ_EN(1)) u_dut (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .mem_ready(mem_ready), .irq(irq),
        .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .WriteSrc(WriteSrc),
        .WriteDest(WriteDest), .CRWrite(CRWrite), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .isBranch(isBranch), .EPCWrite(EPCWrite), .PCSrc(PCSrc), .trap(trap),
        .trap_cause(trap_cause), .current_state(current_state), .next_state(next_state)
    );

    mc_control_fsm #(.OPCODE_W(6), .WAIT_W(4), .MAX_WAIT(MAXW), .IRQ_EN(0)) u_dut_noirq (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .mem_ready(mem_ready), .irq(irq),
        .ALUOp(ALUOp_b), .ALUSrcA(ALUSrcA_b), .ALUSrcB(ALUSrcB_b), .WriteSrc(WriteSrc_b),
        .WriteDest(WriteDest_b), .CRWrite(CRWrite_b), .RegWrite(RegWrite_b), .MemRead(MemRead_b),
        .MemWrite(MemWrite_b), .IorD(IorD_b), .IRWrite(IRWrite_b), .PCWrite(PCWrite_b),
        .isBranch(isBranch_b), .EPCWrite(EPCWrite_b), .PCSrc(PCSrc_b), .trap(trap_b),
        .trap_cause(trap_cause_b), .current_state(current_state_b), .next_state(next_state_b)
    );

    always #5 CLK = ~CLK;

    wire [23:0] act = {ALUOp, ALUSrcA, ALUSrcB, WriteSrc, WriteDest, CRWrite, RegWrite,
                       MemRead, MemWrite, IorD, IRWrite, PCWrite, isBranch, EPCWrite, PCSrc, trap};
    wire [23:0] act_b = {ALUOp_b, ALUSrcA_b, ALUSrcB_b, WriteSrc_b, WriteDest_b, CRWrite_b,
                         RegWrite_b, MemRead_b, MemWrite_b, IorD_b, IRWrite_b, PCWrite_b,
                         isBranch_b, EPCWrite_b, PCSrc_b, trap_b};

    typedef struct packed {
        logic [3:0]  st;
        logic [23:0] ctl;
        logic        mr;
        logic [1:0]  cause;
    } step_t;

    step_t      q[$];
    step_t      exp_cur;
    logic [3:0] exp_next;
    logic       exp_valid = 1'b0;
    logic       b_sync = 1'b1;
    logic [1:0] m_cause = 2'b00;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, a, e);
        end
    endtask

    // Control word: aluop, srcA, srcB, wsrc, wdest,
    // flags {CRW,RegW,MemR,MemW,IorD,IRW,PCW,isBr,EPCW}, pcsrc, trap
    function automatic logic [23:0] cv(input logic [1:0] aop, input logic sa, input logic [2:0] sb,
                                       input logic [2:0] ws, input logic [1:0] wd,
                                       input logic [8:0] fl, input logic [2:0] ps, input logic tr);
        return {aop, sa, sb, ws, wd, fl, ps, tr};
    endfunction

    function automatic logic dc();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic [3:0] st, input logic [23:0] c, input logic r);
        step_t s;
        s.st = st; s.ctl = c; s.mr = r; s.cause = m_cause;
        q.push_back(s);
    endtask

    task automatic push_trap(input logic [1:0] cause);
        m_cause = cause;
        push(4'd13, cv(0, 0, 0, 0, 0, 9'b000000101, 3'd4, 1), dc());
    endtask

    // A memory phase: nwait not-ready cycles then a ready cycle, or a bus timeout.
    task automatic mem_phase(input logic [3:0] st, input logic [23:0] c_wait, input logic [23:0] c_done,
                             input int nwait, output logic ok);
        if (nwait > MAXW) begin
            for (int i = 0; i <= MAXW; i++) push(st, c_wait, 1'b0);
            push_trap(2'b11);
            ok = 1'b0;
        end else begin
            for (int i = 0; i < nwait; i++) push(st, c_wait, 1'b0);
            push(st, c_done, 1'b1);
            ok = 1'b1;
        end
    endtask

    task automatic build(input int op, input int fw, input int mw, input logic ir);
        logic ok;
        q.delete();
        mem_phase(4'd0, cv(0, 0, 1, 0, 0, 9'b001000000, 0, 0),
                  cv(0, 0, 1, 0, 0, 9'b001001100, 0, 0), fw, ok);
        if (!ok) return;
        push(4'd1, cv(0, 0, 3, 0, 0, 9'b0, 0, 0), dc());
        case (op)
            0:    push(4'd2, cv(2, 1, 0, 0, 0, 9'b010000000, 0, 0), dc());
            1, 2: push(4'd3, cv(1, 1, 0, 0, 0, 9'b000000010, 1, 0), dc());
            3:    push(4'd4, cv(0, 0, 0, 0, 0, 9'b000000100, 2, 0), dc());
            4:    push(4'd5, cv(0, 0, 0, 1, 2, 9'b010000100, 2, 0), dc());
            5:    push(4'd6, cv(0, 0, 0, 0, 0, 9'b000000100, 3, 0), dc());
            6, 7: push(4'd7, cv(0, 0, 0, (op == 6) ? 3'd2 : 3'd3, 1, 9'b010000000, 0, 0), dc());
            8:    push(4'd8, cv(0, 0, 0, 4, 1, 9'b010000000, 0, 0), dc());
            9:    push(4'd8, cv(0, 0, 0, 0, 0, 9'b100000000, 0, 0), dc());
            10: begin
                push(4'd9, cv(0, 1, 2, 0, 0, 9'b0, 0, 0), dc());
                mem_phase(4'd10, cv(0, 0, 0, 0, 0, 9'b001010000, 0, 0),
                          cv(0, 0, 0, 0, 0, 9'b001010000, 0, 0), mw, ok);
                if (!ok) return;
                push(4'd11, cv(0, 0, 0, 5, 1, 9'b010000000, 0, 0), dc());
            end
            11: begin
                push(4'd9, cv(0, 1, 2, 0, 0, 9'b0, 0, 0), dc());
                mem_phase(4'd12, cv(0, 0, 0, 0, 0, 9'b000110000, 0, 0),
                          cv(0, 0, 0, 0, 0, 9'b000110000, 0, 0), mw, ok);
                if (!ok) return;
            end
            12: begin
                push_trap(2'b01);
                return;
            end
            default: begin
                push_trap(2'b10);
                return;
            end
        endcase
        if (ir) push_trap(2'b00);
    endtask

    task automatic play(input int op, input logic ir, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            @(negedge CLK);
            if (i == 0) Reset = 1'b0;
            Opcode    = 6'(op);
            irq       = ir;
            mem_ready = q[i].mr;
            exp_cur   = q[i];
            exp_next  = (i + 1 < q.size()) ? q[i+1].st : 4'd0;
            exp_valid = 1'b1;
        end
    endtask

    task automatic run(input int op, input int fw, input int mw, input logic ir);
        build(op, fw, mw, ir);
        play(op, ir, 0, q.size());
    endtask

    always @(negedge CLK) begin
        #2;
        if (exp_valid) begin
            chk("current_state", 32'(current_state), 32'(exp_cur.st));
            chk("next_state", 32'(next_state), 32'(exp_next));
            chk("controls", 32'(act), 32'(exp_cur.ctl));
            chk("trap_cause", 32'(trap_cause), 32'(exp_cur.cause));
            if (b_sync) chk("noirq_state", 32'(current_state_b), 32'(exp_cur.st));
            if (exp_cur.st == 4'd5 && irq) begin
                chk("noirq_jal_next", 32'(next_state_b), 32'd0);
                chk("noirq_jal_ctl", 32'(act_b), 32'(exp_cur.ctl));
                b_sync = 1'b0;
            end
        end
    end

    initial begin
        logic [1:0] saved;
        // Pin the model against hand-derived latencies and one control word.
        saved = m_cause;
        build(0, 0, 0, 1'b0);
        chk("pin_c_len", 32'(q.size()), 32'd3);
        chk("pin_execc_ctl", 32'(q[2].ctl), 32'hA00800);
        build(11, 0, 0, 1'b0);  chk("pin_sw_len", 32'(q.size()), 32'd4);
        build(10, 0, 0, 1'b0);  chk("pin_lw_len", 32'(q.size()), 32'd5);
        build(0, 0, 0, 1'b1);   chk("pin_irq_len", 32'(q.size()), 32'd4);
        build(0, 20, 0, 1'b0);  chk("pin_timeout_len", 32'(q.size()), 32'd17);
        m_cause = saved;

        // Reset state: outputs held at zero even with mem_ready high.
        repeat (2) @(negedge CLK);
        #2;
        chk("rst0_state", 32'(current_state), 32'd0);
        chk("rst0_next", 32'(next_state), 32'd0);
        chk("rst0_ctl", 32'(act), 32'd0);
        chk("rst0_cause", 32'(trap_cause), 32'd0);
        mem_ready = 1'b1;
        #1 chk("rst0_ctl_mr", 32'(act), 32'd0);

        run(0, 0, 0, 1'b0);
        run(1, 2, 0, 1'b0);
        run(2, 0, 0, 1'b0);
        run(3, 1, 0, 1'b0);
        run(4, 0, 0, 1'b0);
        run(5, 0, 0, 1'b0);
        run(6, 0, 0, 1'b0);
        run(7, 3, 0, 1'b0);
        run(8, 0, 0, 1'b0);
        run(9, 0, 0, 1'b0);
        run(10, 0, 3, 1'b0);
        run(11, 0, 2, 1'b0);
        run(11, 0, 15, 1'b0);
        run(0, 15, 0, 1'b0);
        run(0, 20, 0, 1'b0);
        run(10, 0, 16, 1'b0);
        run(11, 0, 30, 1'b0);
        run(12, 0, 0, 1'b0);
        run(63, 0, 0, 1'b0);
        run(13, 0, 0, 1'b0);
        run(4, 0, 0, 1'b1);
        run(0, 0, 0, 1'b1);
        run(11, 0, 1, 1'b1);
        run(10, 0, 0, 1'b1);
        run(12, 0, 0, 1'b1);
        run(63, 0, 0, 1'b0);

        // Abort a store mid-wait with an asynchronous reset.
        build(11, 0, 3, 1'b0);
        play(11, 1'b0, 0, 4);
        @(negedge CLK);
        exp_valid = 1'b0;
        mem_ready = 1'b0;
        #1 Reset = 1'b1;
        #1;
        chk("rst6_state", 32'(current_state), 32'd0);
        chk("rst6_next", 32'(next_state), 32'd0);
        chk("rst6_ctl", 32'(act), 32'd0);
        chk("rst6_cause", 32'(trap_cause), 32'd0);
        mem_ready = 1'b1;
        #1 chk("rst6_ctl_mr", 32'(act), 32'd0);
        @(negedge CLK);
        m_cause = 2'b00;
        run(9, 0, 0, 1'b0);
        run(0, 1, 0, 1'b0);
        @(negedge CLK);
        exp_valid = 1'b0;
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
